// File: rtl/sdram_host_master.sv
// sdram_host_master: host-side block initiator for the SDRAM controller.
// Takes one block command (direction, start word address, length) and runs
// that many single-word accesses at consecutive addresses, feeding write
// words from a valid/ready input stream and returning read words on a
// valid/ready output stream. Each access is bounded by a done timeout.
module sdram_host_master #(
  parameter int unsigned AW      = 24,
  parameter int unsigned DW      = 16,
  parameter int unsigned LW      = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wdat_valid,
  output logic          wdat_ready,
  input  logic [DW-1:0] wdat,
  output logic          rdat_valid,
  input  logic          rdat_ready,
  output logic [DW-1:0] rdat,
  output logic          busy,
  output logic          xfer_done,
  output logic          xfer_err,
  output logic          host_rd_o,
  output logic          host_wr_o,
  output logic [AW-1:0] host_addr_o,
  output logic [DW-1:0] host_data_o,
  input  logic [DW-1:0] host_data_i,
  input  logic          host_done_i
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WFETCH = 3'd1;
  localparam logic [2:0] S_WACC   = 3'd2;
  localparam logic [2:0] S_RACC   = 3'd3;
  localparam logic [2:0] S_RHOLD  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  // Counter wide enough to hold TIMEOUT; the abort fires on the cycle the
  // counter reaches TIMEOUT-1, i.e. after TIMEOUT cycles of waiting.
  localparam int unsigned   TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    state_q,  state_d;
  logic [AW-1:0] addr_q,   addr_d;
  logic [LW-1:0] cnt_q,    cnt_d;
  logic [TW-1:0] tmo_q,    tmo_d;
  logic          err_q,    err_d;
  logic          live_q,   live_d;
  logic          rd_q,     rd_d;
  logic          wr_q,     wr_d;
  logic [DW-1:0] wdata_q,  wdata_d;
  logic [DW-1:0] rdat_q,   rdat_d;
  logic          rvalid_q, rvalid_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic          xerr_q,   xerr_d;
  logic          tmo_hit_s;

  // live_q keeps cmd_ready low until the first edge after reset releases
  assign cmd_ready   = live_q & (state_q == S_IDLE);
  assign wdat_ready  = (state_q == S_WFETCH) & wdat_valid;
  assign tmo_hit_s   = (tmo_q == TMO_LAST);

  assign rdat_valid  = rvalid_q;
  assign rdat        = rdat_q;
  assign busy        = busy_q;
  assign xfer_done   = done_q;
  assign xfer_err    = xerr_q;
  assign host_rd_o   = rd_q;
  assign host_wr_o   = wr_q;
  assign host_addr_o = addr_q;
  assign host_data_o = wdata_q;

  // Next-state and next-output logic for the block transfer sequencer
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    live_d   = 1'b1;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    rdat_d   = rdat_q;
    rvalid_d = rvalid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    xerr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && live_q) begin
          addr_d = cmd_addr;
          cnt_d  = cmd_len;
          busy_d = 1'b1;
          err_d  = 1'b0;
          tmo_d  = {TW{1'b0}};
          if (cmd_len == {LW{1'b0}}) begin
            state_d = S_FINISH;
          end else if (cmd_write) begin
            state_d = S_WFETCH;
          end else begin
            state_d = S_RACC;
            rd_d    = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WFETCH: begin
        // a stalled write stream is waited on without any timeout
        if (wdat_valid) begin
          wdata_d = wdat;
          wr_d    = 1'b1;
          tmo_d   = {TW{1'b0}};
          state_d = S_WACC;
        end else begin
          state_d = S_WFETCH;
        end
      end
      S_WACC: begin
        if (host_done_i) begin
          wr_d   = 1'b0;
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q - LW'(1);
          // going back through WFETCH guarantees a wr-low cycle between words
          if (cnt_q == LW'(1)) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_WFETCH;
          end
        end else if (tmo_hit_s) begin
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RACC: begin
        if (host_done_i) begin
          rdat_d   = host_data_i;
          rvalid_d = 1'b1;
          rd_d     = 1'b0;
          addr_d   = addr_q + AW'(1);
          cnt_d    = cnt_q - LW'(1);
          state_d  = S_RHOLD;
        end else if (tmo_hit_s) begin
          rd_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RHOLD: begin
        // next read is only issued once the consumer has taken this word
        if (rdat_ready) begin
          rvalid_d = 1'b0;
          if (cnt_q == {LW{1'b0}}) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_RACC;
            rd_d    = 1'b1;
            tmo_d   = {TW{1'b0}};
          end
        end else begin
          state_d = S_RHOLD;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        xerr_d  = err_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        rvalid_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset clears all
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q  <= S_IDLE;
      addr_q   <= {AW{1'b0}};
      cnt_q    <= {LW{1'b0}};
      tmo_q    <= {TW{1'b0}};
      err_q    <= 1'b0;
      live_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= {DW{1'b0}};
      rdat_q   <= {DW{1'b0}};
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      xerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      live_q   <= live_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      rdat_q   <= rdat_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      xerr_q   <= xerr_d;
    end
  end

endmodule

// File: tb/tb_sdram_host_master.sv
// tb_sdram_host_master: scoreboard bench. A block-level reference model turns
// each command into expected controller accesses, read words and a completion
// flag; independent monitors pop and compare when the DUT presents them.
module tb_sdram_host_master;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset_l, cmd_valid, cmd_ready, cmd_write;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        wdat_valid, wdat_ready;
  logic [15:0] wdat;
  logic        rdat_valid, rdat_ready;
  logic [15:0] rdat;
  logic        busy, xfer_done, xfer_err;
  logic        host_rd_o, host_wr_o;
  logic [23:0] host_addr_o;
  logic [15:0] host_data_o, host_data_i;
  logic        host_done_i;

  sdram_host_master #(.AW(24), .DW(16), .LW(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_l(reset_l),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
    .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat(rdat),
    .busy(busy), .xfer_done(xfer_done), .xfer_err(xfer_err),
    .host_rd_o(host_rd_o), .host_wr_o(host_wr_o), .host_addr_o(host_addr_o),
    .host_data_o(host_data_o), .host_data_i(host_data_i), .host_done_i(host_done_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
    logic [15:0] data;
  } acc_t;

  acc_t        exp_acc[$];
  logic [15:0] exp_rd[$];
  bit          exp_done[$];
  logic [15:0] wq[$];
  logic [15:0] dir_words[$];
  logic [15:0] ref_mem[bit [23:0]];
  logic [15:0] ctrl_mem[bit [23:0]];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int exp_lat = -1;
  int wr_run = 0;
  int last_wr_run = 0;
  int c_lat_fixed = 0;
  bit c_never = 1'b0;
  bit stray_en = 1'b0;
  bit rdy_rand = 1'b0;
  bit wv_rand = 1'b0;
  int stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic logic [15:0] init_val(input logic [23:0] a);
    return {a[7:0] ^ a[23:16], a[15:8] ^ 8'h5A};
  endfunction

  function automatic logic [15:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] ctrl_rd(input logic [23:0] a);
    return ctrl_mem.exists(a) ? ctrl_mem[a] : init_val(a);
  endfunction

  // Reference model: a block of len words at addr (mod 2^24); abort means the
  // first access never completes, so only it is seen and an error is reported.
  task automatic model_cmd(input bit wr, input logic [23:0] addr, input int len, input bit abort);
    int n;
    logic [23:0] a;
    logic [15:0] w;
    acc_t e;
    n = abort ? 1 : len;
    exp_done.push_back(abort);
    for (int i = 0; i < n; i++) begin
      a = addr + 24'(i);
      if (wr) begin
        w = (dir_words.size() > 0) ? dir_words.pop_front() : 16'($urandom);
        wq.push_back(w);
        e = '{1'b1, a, w};
        if (!abort) ref_mem[a] = w;
      end else begin
        e = '{1'b0, a, 16'h0000};
        if (!abort) exp_rd.push_back(ref_rd(a));
      end
      exp_acc.push_back(e);
    end
  endtask

  task automatic send_cmd(input bit wr, input logic [23:0] addr, input logic [15:0] len);
    int t;
    t = 0;
    cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (cmd_ready !== 1'b1 && t < 300);
    if (cmd_ready !== 1'b1) flag_fail("cmd_accept_timeout");
    accept_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (exp_done.size() > 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_complete_pending"}, exp_done.size(), 0);
    @(posedge clk); #1;
    chk({name, "_leftover_access"}, exp_acc.size(), 0);
    chk({name, "_leftover_rdat"}, exp_rd.size(), 0);
    chk({name, "_leftover_wdat"}, wq.size(), 0);
  endtask

  // Controller model: done after a latency, memory behind it
  initial begin : ctrl_model
    bit c_busy;
    int c_rem;
    bit req;
    c_busy = 1'b0; c_rem = 0;
    host_done_i = 1'b0; host_data_i = 16'h0000;
    forever begin
      @(posedge clk); #1;
      host_done_i = 1'b0;
      host_data_i = 16'($urandom);
      req = (host_rd_o === 1'b1) || (host_wr_o === 1'b1);
      if (c_busy) begin
        if (!req) begin
          c_busy = 1'b0;
        end else begin
          c_rem--;
          if (c_rem == 0) begin
            host_done_i = 1'b1;
            if (host_wr_o === 1'b1) ctrl_mem[host_addr_o] = host_data_o;
            else host_data_i = ctrl_rd(host_addr_o);
            c_busy = 1'b0;
          end
        end
      end else if (req) begin
        c_busy = 1'b1;
        c_rem = c_never ? 32'h4000_0000 : ((c_lat_fixed > 0) ? c_lat_fixed : $urandom_range(1, 6));
      end else if (stray_en && $urandom_range(0, 7) == 0) begin
        host_done_i = 1'b1;
      end
    end
  end

  // Write-word source
  initial begin : wdat_drv
    bit w_hs;
    wdat_valid = 1'b0; wdat = 16'h0000;
    forever begin
      @(negedge clk);
      w_hs = (wdat_valid === 1'b1) && (wdat_ready === 1'b1);
      @(posedge clk); #1;
      if (w_hs && wq.size() > 0) void'(wq.pop_front());
      if (wq.size() > 0 && (!wv_rand || $urandom_range(0, 3) != 0)) begin
        wdat_valid = 1'b1; wdat = wq[0];
      end else begin
        wdat_valid = 1'b0; wdat = 16'($urandom);
      end
    end
  end

  // Read-word consumer with optional stall on first word and random backpressure
  initial begin : rdy_drv
    rdat_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rdat_valid === 1'b1 && stall_left > 0) begin
        rdat_ready = 1'b0;
        stall_left--;
      end else begin
        rdat_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Access monitor: each new rd/wr request is compared to the next expected one
  initial begin : acc_mon
    bit prev_req, req;
    acc_t e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      req = (host_rd_o === 1'b1) || (host_wr_o === 1'b1);
      if (req) begin
        chk("rd_wr_exclusive", host_rd_o & host_wr_o, 1'b0);
        chk("busy_during_access", busy, 1'b1);
      end
      if (host_rd_o === 1'b1) chk("rd_while_rdat_pending", rdat_valid, 1'b0);
      if (busy === 1'b1) chk("cmd_ready_while_busy", cmd_ready, 1'b0);
      if (req && !prev_req) begin
        if (exp_acc.size() == 0) begin
          flag_fail("unexpected_access");
        end else begin
          e = exp_acc.pop_front();
          chk("access_dir_wr", host_wr_o, e.wr);
          chk("access_addr", host_addr_o, e.addr);
          if (e.wr) chk("access_wdata", host_data_o, e.data);
        end
      end
      if (host_wr_o === 1'b1) begin
        wr_run++;
      end else if (wr_run > 0) begin
        last_wr_run = wr_run;
        wr_run = 0;
      end
      prev_req = req;
    end
  end

  // Read-stream monitor: ordering, values and hold-under-backpressure
  initial begin : rd_mon
    logic pv, pr;
    logic [15:0] pd, e;
    pv = 1'b0; pr = 1'b0; pd = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset_l === 1'b1 && pv === 1'b1 && pr === 1'b0) begin
        chk("rdat_hold_valid", rdat_valid, 1'b1);
        chk("rdat_hold_data", rdat, pd);
      end
      if (rdat_valid === 1'b1 && rdat_ready === 1'b1) begin
        if (exp_rd.size() == 0) begin
          flag_fail("unexpected_rdat");
        end else begin
          e = exp_rd.pop_front();
          chk("rdat_value", rdat, e);
        end
      end
      pv = rdat_valid; pr = rdat_ready; pd = rdat;
    end
  end

  // Completion monitor
  initial begin : done_mon
    bit e;
    forever begin
      @(negedge clk);
      if (xfer_err === 1'b1 && xfer_done !== 1'b1) flag_fail("xfer_err_without_done");
      if (xfer_done === 1'b1) begin
        if (exp_done.size() == 0) begin
          flag_fail("unexpected_xfer_done");
        end else begin
          e = exp_done.pop_front();
          chk("xfer_err", xfer_err, e);
          chk("busy_at_done", busy, 1'b0);
          if (exp_lat >= 0) begin
            chk("zero_len_done_latency", cyc - accept_cyc, exp_lat);
            exp_lat = -1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    bit wr;
    logic [23:0] a;
    int len;
    reset_l = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 24'h0; cmd_len = 16'h0;

    // Reset with cmd_valid held high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", {host_rd_o, host_wr_o, host_addr_o, host_data_o, rdat_valid,
                            rdat, busy, xfer_done, xfer_err}, 64'h0);
      chk("reset_cmd_ready", cmd_ready, 1'b0);
    end
    reset_l = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_release", cmd_ready, 1'b1);
    cmd_valid = 1'b0;
    @(posedge clk); #1;

    // Directed write block, fixed latency
    c_lat_fixed = 4;
    dir_words.push_back(16'hA5A5); dir_words.push_back(16'h1234); dir_words.push_back(16'hFFFF);
    model_cmd(1'b1, 24'h000100, 3, 1'b0);
    send_cmd(1'b1, 24'h000100, 16'd3);
    wait_done("write3");

    // Read with backpressure on the first word
    ref_mem[24'h000020] = 16'hBEEF; ctrl_mem[24'h000020] = 16'hBEEF;
    ref_mem[24'h000021] = 16'hCAFE; ctrl_mem[24'h000021] = 16'hCAFE;
    stall_left = 5;
    model_cmd(1'b0, 24'h000020, 2, 1'b0);
    send_cmd(1'b0, 24'h000020, 16'd2);
    wait_done("read_bp");

    // Address wrap
    c_lat_fixed = 0;
    model_cmd(1'b0, 24'hFFFFFE, 3, 1'b0);
    send_cmd(1'b0, 24'hFFFFFE, 16'd3);
    wait_done("read_wrap");

    // Zero length
    exp_lat = 2;
    model_cmd(1'b1, 24'h000055, 0, 1'b0);
    send_cmd(1'b1, 24'h000055, 16'd0);
    wait_done("zero_len");

    // Timeout on a write that never completes
    c_never = 1'b1;
    model_cmd(1'b1, 24'h000300, 2, 1'b1);
    send_cmd(1'b1, 24'h000300, 16'd2);
    wait_done("timeout");
    chk("timeout_wr_cycles", last_wr_run, TMO);
    chk("idle_after_timeout", cmd_ready, 1'b1);

    // Reset during a read access
    model_cmd(1'b0, 24'h000400, 3, 1'b0);
    send_cmd(1'b0, 24'h000400, 16'd3);
    t = 0;
    while (host_rd_o !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rd_before_reset", host_rd_o, 1'b1);
    @(negedge clk);
    reset_l = 1'b0;
    exp_acc.delete(); exp_rd.delete(); exp_done.delete(); wq.delete();
    @(negedge clk);
    chk("rd_dropped_by_reset", host_rd_o, 1'b0);
    chk("busy_cleared_by_reset", busy, 1'b0);
    @(negedge clk);
    reset_l = 1'b1;
    c_never = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    model_cmd(1'b0, 24'h000400, 2, 1'b0);
    send_cmd(1'b0, 24'h000400, 16'd2);
    wait_done("after_reset");

    // Randomized blocks against the model
    stray_en = 1'b1; rdy_rand = 1'b1; wv_rand = 1'b1;
    for (int k = 0; k < 30; k++) begin
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: a = 24'h000100 + 24'($urandom_range(0, 15));
        1: a = 24'hFFFFF8 + 24'($urandom_range(0, 7));
        default: a = 24'($urandom);
      endcase
      len = $urandom_range(0, 6);
      model_cmd(wr, a, len, 1'b0);
      send_cmd(wr, a, 16'(len));
      wait_done("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_host_master.md
Name: sdram_host_master

Overview:
- Host-side initiator for the SDRAM controller host interface; drives the controller's rd/wr/addr/data handshake and consumes done/data_o.
- Accepts one block command (direction, 24-bit word address, length) and performs that many single-word accesses at consecutive addresses.
- On writes, words come from a valid/ready input stream. On reads, words go to a valid/ready output stream.
- Sits between datapath blocks (e.g. the wavelet/jpeg pipeline) and the SDRAM controller.

Parameters:
- AW, 24, host address width (matches controller).
- DW, 16, data width.
- LW, 16, length field width.
- TIMEOUT, 1023, max cycles to wait for host_done_i per access before error abort.

Ports:
- clk  in  1  system clock
- reset_l  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle, command accepted when valid&ready
- cmd_write  in  1  1=write block, 0=read block
- cmd_addr  in  AW  start word address
- cmd_len  in  LW  word count; 0 is legal
- wdat_valid  in  1  write word available
- wdat_ready  out  1  write word consumed this cycle
- wdat  in  DW  write data
- rdat_valid  out  1  read word available
- rdat_ready  in  1  consumer accepts read word
- rdat  out  DW  read data
- busy  out  1  transfer in progress
- xfer_done  out  1  one-cycle pulse at end of command
- xfer_err  out  1  one-cycle pulse (coincident with xfer_done) on timeout abort
- host_rd_o  out  1  read request to controller
- host_wr_o  out  1  write request to controller
- host_addr_o  out  AW  access address
- host_data_o  out  DW  write data to controller
- host_data_i  in  DW  read data from controller (valid when host_done_i=1 on reads)
- host_done_i  in  1  controller access complete, one-cycle pulse

Behaviour:
- All outputs registered except cmd_ready (=state IDLE) and wdat_ready (=state WFETCH & wdat_valid).
- Reset (reset_l=0 at a clk edge) forces IDLE and clears all registered outputs: host_rd_o=0, host_wr_o=0, host_addr_o=0, host_data_o=0, rdat_valid=0, rdat=0, busy=0, xfer_done=0, xfer_err=0.
  - Reset mid-access drops rd/wr on the next edge.
  - In-flight data is discarded; no xfer_done is issued.
- States: IDLE, WFETCH, WACC, RACC, RHOLD, FINISH.
- IDLE:
  - cmd_valid accepted: latch addr, remaining count=cmd_len, direction; busy=1.
  - len=0 -> FINISH.
  - write -> WFETCH.
  - read -> RACC with host_rd_o=1.
- WFETCH: on wdat_valid, capture wdat into host_data_o, set host_wr_o=1, go WACC. A stalled stream waits indefinitely; no timeout here.
- WACC:
  - Hold host_wr_o/addr/data stable until host_done_i.
  - On done: host_wr_o=0 next cycle, addr+1, count-1.
  - If count becomes 0 -> FINISH, else WFETCH.
  - Minimum one cycle with wr deasserted between accesses.
- RACC:
  - Hold host_rd_o/addr until host_done_i.
  - On done: rdat<=host_data_i, rdat_valid=1, host_rd_o=0, addr+1, count-1 -> RHOLD.
- RHOLD:
  - rdat held stable while rdat_valid & !rdat_ready.
  - On rdat_ready: rdat_valid=0; count 0 -> FINISH, else RACC with host_rd_o=1 next cycle.
  - No new read is issued until the previous word is accepted.
- FINISH: xfer_done=1 for one cycle, busy=0, go IDLE. cmd_ready is 0 during FINISH.
- Address arithmetic is modulo 2^AW: 0xFFFFFF+1 wraps to 0x000000 silently.
- Timeout:
  - A cycle counter runs in WACC/RACC and resets on entry to either state.
  - On reaching TIMEOUT without done: drop rd/wr, go FINISH with xfer_err=1.
  - Remaining words are not transferred; nothing is emitted on rdat.
- A host_done_i seen outside WACC/RACC is ignored.
- cmd_valid while busy is ignored (cmd_ready=0).
- host_rd_o and host_wr_o are never both 1.

Test Plan:
- Reset: hold reset_l=0 for 3 cycles with cmd_valid=1 -> all outputs 0, cmd_ready=0 during reset, 1 after first edge with reset_l=1.
- Write block: addr=0x000100, len=3, words 0xA5A5/0x1234/0xFFFF, controller done 4 cycles after wr -> three wr accesses at 0x100/0x101/0x102 with matching host_data_o, wr low ≥1 cycle between, single xfer_done, xfer_err=0.
- Read with backpressure: addr=0x000020, len=2, model returns 0xBEEF/0xCAFE, rdat_ready low 5 cycles on first word -> rdat stays 0xBEEF with rdat_valid=1; second rd not issued until accept; both words delivered in order.
- Wrap: read addr=0xFFFFFE, len=3 -> host_addr_o sequence 0xFFFFFE, 0xFFFFFF, 0x000000.
- Zero length and timeout: len=0 -> xfer_done 2 cycles after accept, no rd/wr. Write len=2 with model never asserting done (TIMEOUT=15) -> wr dropped after 15 cycles, xfer_done&xfer_err pulse, back to IDLE.
- Reset mid-read: assert reset_l=0 while host_rd_o=1 -> rd low after the edge, no xfer_done; a new command after release completes normally.
